// File: rtl/write_through_buffer.sv
// Posted write buffer between the L1 write-through port and main memory.
// Coalesces same-address writes, drains over req/ack and forwards reads from buffered data.
module write_through_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_req,
  input  logic              in_write,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_write_data,
  output logic [DATA_W-1:0] in_read_data,
  output logic              fwd_hit,
  output logic              buf_full,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  output logic              wr_drop,
  output logic [31:0]       drop_count,
  output logic [31:0]       coalesce_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic              mem_wr_req_q, mem_wr_req_d;
  logic [ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic              wr_drop_q, wr_drop_d;
  logic [31:0]       drop_count_q, drop_count_d;
  logic [31:0]       coalesce_count_q, coalesce_count_d;

  logic              full;
  logic              coal_hit;
  logic [PTR_W-1:0]  coal_idx;
  logic [PTR_W-1:0]  rd_idx;
  logic              do_wr, do_coal, do_enq, do_drop, do_pop;

  assign full           = (count_q == CNT_W'(DEPTH));
  assign buf_full       = full;
  assign mem_rd_addr    = in_addr;
  assign mem_wr_req     = mem_wr_req_q;
  assign mem_wr_addr    = mem_wr_addr_q;
  assign mem_wr_data    = mem_wr_data_q;
  assign wr_drop        = wr_drop_q;
  assign drop_count     = drop_count_q;
  assign coalesce_count = coalesce_count_q;

  // Read forwarding: walk oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit      = 1'b0;
    in_read_data = mem_rd_data;
    rd_idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rd_idx = head_q + PTR_W'(i);
      if (valid_q[rd_idx] && (addr_q[rd_idx] == in_addr)) begin
        fwd_hit      = 1'b1;
        in_read_data = data_q[rd_idx];
      end
    end
  end

  // Coalesce target: any matching entry except the head already presented to memory
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == in_addr) &&
          !((state_q == ST_BUSY) && (PTR_W'(i) == head_q))) begin
        coal_hit = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    valid_d          = valid_q;
    addr_d           = addr_q;
    data_d           = data_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    state_d          = state_q;
    mem_wr_req_d     = mem_wr_req_q;
    mem_wr_addr_d    = mem_wr_addr_q;
    mem_wr_data_d    = mem_wr_data_q;
    wr_drop_d        = 1'b0;
    drop_count_d     = drop_count_q;
    coalesce_count_d = coalesce_count_q;

    do_wr   = in_req & in_write;
    do_coal = do_wr & coal_hit;
    do_enq  = do_wr & ~coal_hit & ~full;
    do_drop = do_wr & ~coal_hit & full;
    do_pop  = (state_q == ST_BUSY) & mem_wr_ack;

    if (do_coal) begin
      data_d[coal_idx] = in_write_data;
      coalesce_count_d = coalesce_count_q + 32'd1;
    end
    if (do_enq) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = in_addr;
      data_d[tail_q]  = in_write_data;
      tail_d          = tail_q + PTR_W'(1);
    end
    if (do_drop) begin
      wr_drop_d    = 1'b1;
      drop_count_d = drop_count_q + 32'd1;
    end
    if (do_pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_enq) - CNT_W'(do_pop);

    // Drain FSM; a same-cycle coalesce into the head being loaded is forwarded
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          mem_wr_addr_d = addr_q[head_q];
          mem_wr_data_d = (do_coal && (coal_idx == head_q)) ? in_write_data : data_q[head_q];
          mem_wr_req_d  = 1'b1;
          state_d       = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_wr_ack) begin
          mem_wr_req_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q          <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      state_q          <= ST_IDLE;
      mem_wr_req_q     <= 1'b0;
      mem_wr_addr_q    <= '0;
      mem_wr_data_q    <= '0;
      wr_drop_q        <= 1'b0;
      drop_count_q     <= '0;
      coalesce_count_q <= '0;
    end else begin
      valid_q          <= valid_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      state_q          <= state_d;
      mem_wr_req_q     <= mem_wr_req_d;
      mem_wr_addr_q    <= mem_wr_addr_d;
      mem_wr_data_q    <= mem_wr_data_d;
      wr_drop_q        <= wr_drop_d;
      drop_count_q     <= drop_count_d;
      coalesce_count_q <= coalesce_count_d;
    end
  end

  // Entry payloads need no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_write_through_buffer.sv
// Self-checking bench for write_through_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model of the buffer.
module tb_write_through_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_req, in_write;
  logic [31:0] in_addr, in_write_data, in_read_data;
  logic        fwd_hit, buf_full;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic        mem_wr_ack, wr_drop;
  logic [31:0] drop_count, coalesce_count;

  always #5 clk = ~clk;

  write_through_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_write(in_write), .in_addr(in_addr),
    .in_write_data(in_write_data), .in_read_data(in_read_data), .fwd_hit(fwd_hit),
    .buf_full(buf_full), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack), .wr_drop(wr_drop), .drop_count(drop_count),
    .coalesce_count(coalesce_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  // Reference model: oldest entry at index 0, head in flight when m_busy
  ent_t        mq[$];
  ent_t        dut_log[$];
  bit          m_busy, m_req, m_drop;
  logic [31:0] m_waddr, m_wdata;
  logic [31:0] m_drops, m_coals;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_req = 0; m_drop = 0;
    m_waddr = '0; m_wdata = '0; m_drops = '0; m_coals = '0;
  endtask

  task automatic model_step(input bit req, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input bit ack);
    int sz;
    int j;
    sz = int'(mq.size());
    j = -1;
    m_drop = 0;
    if (req && wr) begin
      for (int k = 0; k < sz; k++)
        if (mq[k].addr == a && !(m_busy && k == 0)) j = k;
      if (j >= 0) begin
        mq[j].data = d;
        m_coals++;
      end else if (sz < int'(DEPTH)) begin
        mq.push_back(ent_t'{a, d});
      end else begin
        m_drop = 1;
        m_drops++;
      end
    end
    if (!m_busy) begin
      if (sz > 0) begin
        m_waddr = mq[0].addr;
        m_wdata = mq[0].data;
        m_req = 1;
        m_busy = 1;
      end
    end else if (ack) begin
      m_req = 0;
      m_busy = 0;
      void'(mq.pop_front());
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs
  task automatic cycle(input bit rst, input bit req, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit ack, input logic [31:0] rd);
    bit          e_hit;
    logic [31:0] e_rd;
    reset = rst; in_req = req; in_write = wr; in_addr = a;
    in_write_data = d; mem_wr_ack = ack; mem_rd_data = rd;
    #2;
    if (!rst) begin
      e_hit = 0;
      e_rd = rd;
      foreach (mq[k]) if (mq[k].addr == a) begin e_hit = 1; e_rd = mq[k].data; end
      chk("fwd_hit", 64'(fwd_hit), 64'(e_hit));
      chk("in_read_data", 64'(in_read_data), 64'(e_rd));
      chk("buf_full", 64'(buf_full), 64'(mq.size() == DEPTH));
      chk("mem_rd_addr", 64'(mem_rd_addr), 64'(a));
      if (mem_wr_req && ack) dut_log.push_back(ent_t'{mem_wr_addr, mem_wr_data});
      model_step(req, wr, a, d, ack);
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    chk("mem_wr_req", 64'(mem_wr_req), 64'(m_req));
    chk("mem_wr_addr", 64'(mem_wr_addr), 64'(m_waddr));
    chk("mem_wr_data", 64'(mem_wr_data), 64'(m_wdata));
    chk("wr_drop", 64'(wr_drop), 64'(m_drop));
    chk("drop_count", 64'(drop_count), 64'(m_drops));
    chk("coalesce_count", 64'(coalesce_count), 64'(m_coals));
  endtask

  task automatic do_rst();
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    dut_log.delete();
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input bit ack);
    cycle(1'b0, 1'b1, 1'b1, a, d, ack, 32'hDEAD_BEEF);
  endtask

  task automatic do_idle(input bit ack, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0, ack, 32'h0);
  endtask

  initial begin
    reset = 1'b1; in_req = 0; in_write = 0; in_addr = '0;
    in_write_data = '0; mem_wr_ack = 0; mem_rd_data = '0;
    model_reset();

    // Reset state and single write with ack tied high
    do_rst();
    chk("rst_full", 64'(buf_full), 64'(0));
    do_wr(32'h100, 32'h11, 1'b1);
    do_idle(1'b1, 1);
    chk("t1_req", 64'(mem_wr_req), 64'(1));
    chk("t1_addr", 64'(mem_wr_addr), 64'h100);
    chk("t1_data", 64'(mem_wr_data), 64'h11);
    do_idle(1'b1, 3);
    chk("t1_drained", 64'(dut_log.size()), 64'(1));

    // Fill, drop, then drain in order
    do_rst();
    for (int k = 0; k < 4; k++) do_wr(32'h100 + 32'(4 * k), 32'h20 + 32'(k), 1'b0);
    chk("t2_full", 64'(buf_full), 64'(1));
    do_wr(32'h110, 32'h99, 1'b0);
    chk("t2_drop", 64'(wr_drop), 64'(1));
    chk("t2_drop_count", 64'(drop_count), 64'(1));
    do_idle(1'b1, 10);
    chk("t2_log_n", 64'(dut_log.size()), 64'(4));
    for (int k = 0; k < 4 && k < int'(dut_log.size()); k++)
      chk("t2_order", 64'(dut_log[k].addr), 64'(32'h100 + 32'(4 * k)));

    // Coalesce behind the in-flight head
    do_rst();
    do_wr(32'h200, 32'hA, 1'b0);
    do_wr(32'h204, 32'hB, 1'b0);
    do_wr(32'h204, 32'hC, 1'b0);
    chk("t3_coal", 64'(coalesce_count), 64'(1));
    do_idle(1'b1, 6);
    chk("t3_log_n", 64'(dut_log.size()), 64'(2));
    if (dut_log.size() == 2) chk("t3_data", 64'(dut_log[1].data), 64'hC);

    // Read forwarding versus memory pass-through
    do_rst();
    do_wr(32'h300, 32'h55, 1'b0);
    in_req = 1; in_write = 0; in_addr = 32'h300; mem_rd_data = 32'h77;
    #1;
    chk("t4_hit", 64'(fwd_hit), 64'(1));
    chk("t4_fwd", 64'(in_read_data), 64'h55);
    in_addr = 32'h304;
    #1;
    chk("t4_miss", 64'(fwd_hit), 64'(0));
    chk("t4_mem", 64'(in_read_data), 64'h77);
    cycle(1'b0, 1'b1, 1'b0, 32'h304, 32'h0, 1'b0, 32'h77);

    // Write to the in-flight head address enqueues a new entry
    do_rst();
    do_wr(32'h400, 32'h1, 1'b0);
    do_idle(1'b0, 1);
    do_wr(32'h400, 32'h9, 1'b0);
    chk("t5_no_coal", 64'(coalesce_count), 64'(0));
    do_idle(1'b1, 6);
    chk("t5_log_n", 64'(dut_log.size()), 64'(2));
    if (dut_log.size() == 2) begin
      chk("t5_old", 64'(dut_log[0].data), 64'h1);
      chk("t5_new", 64'(dut_log[1].data), 64'h9);
    end

    // Reset while draining discards everything
    do_rst();
    for (int k = 0; k < 3; k++) do_wr(32'h500 + 32'(4 * k), 32'h30 + 32'(k), 1'b0);
    chk("t6_busy", 64'(mem_wr_req), 64'(1));
    do_rst();
    chk("t6_req", 64'(mem_wr_req), 64'(0));
    do_idle(1'b1, 4);
    chk("t6_full", 64'(buf_full), 64'(0));
    chk("t6_no_drain", 64'(dut_log.size()), 64'(0));

    // Random traffic over a small address set to provoke coalescing and drops
    do_rst();
    for (int n = 0; n < 600; n++) begin
      int unsigned op;
      int unsigned ack_thr;
      op = $urandom % 4;
      ack_thr = (n < 300) ? 2 : 6;
      cycle(($urandom % 150) == 0, op != 0, op <= 2,
            32'h600 + 32'(4 * ($urandom % 6)), $urandom,
            ($urandom % 8) < ack_thr, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
